// File: rtl/wr_phy_link_sequencer.sv
// SFP/GTP link bring-up and supervision FSM: PLL lock, PHY reset, reset-done, alignment, link-up, backoff/retry.
// Define WR_LINK_SEQ_STATS_EN to build the link-up entry and encoding-error statistics counters.
module wr_phy_link_sequencer #(
  parameter int g_simulation    = 0,
  parameter int g_rst_len       = 1000,
  parameter int g_align_timeout = 2000000,
  parameter int g_backoff_len   = 100000,
  parameter int g_err_window    = 65536,
  parameter int g_err_threshold = 16
) (
  input  logic        clk_sys_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic        los_i,
  input  logic        pll_locked_i,
  output logic        gtp_rst_o,
  input  logic        gtp_reset_done_i,
  input  logic        rx_aligned_i,
  input  logic        rx_enc_err_i,
  output logic        tx_enable_o,
  output logic        link_up_o,
  output logic [2:0]  state_o,
  output logic [7:0]  retry_cnt_o,
  output logic [15:0] link_up_cnt_o,
  output logic [31:0] err_total_o
);

  typedef enum logic [2:0] {
    S_IDLE          = 3'd0,
    S_WAIT_PLL      = 3'd1,
    S_RESET_PHY     = 3'd2,
    S_WAIT_RST_DONE = 3'd3,
    S_WAIT_ALIGN    = 3'd4,
    S_LINK_UP       = 3'd5,
    S_BACKOFF       = 3'd6
  } t_state;

  localparam int c_rst_len       = (g_simulation != 0) ? 16  : g_rst_len;
  localparam int c_align_timeout = (g_simulation != 0) ? 256 : g_align_timeout;
  localparam int c_backoff_len   = (g_simulation != 0) ? 64  : g_backoff_len;
  localparam int c_err_window    = (g_simulation != 0) ? 128 : g_err_window;

  localparam logic [23:0] c_rst_last     = 24'(c_rst_len - 1);
  localparam logic [23:0] c_align_last   = 24'(c_align_timeout - 1);
  localparam logic [23:0] c_backoff_last = 24'(c_backoff_len - 1);
  localparam logic [23:0] c_win_last     = 24'(c_err_window - 1);
  localparam logic [8:0]  c_err_thresh   = 9'(g_err_threshold);

  t_state      r_state;
  logic [23:0] r_timer;
  logic [3:0]  r_run_cnt;
  logic [7:0]  r_err_cnt;
  logic        r_gtp_rst;
  logic        r_tx_en;
  logic        r_link_up;
  logic [7:0]  r_retry_cnt;

  t_state      w_state_next;
  logic        w_state_change;
  logic        w_align_good;
  logic        w_win_start;
  logic        w_win_last;
  logic [8:0]  w_err_sum;

  // In LINK_UP the state timer doubles as the error window counter; timer==0 opens a new window.
  always_comb begin
    w_align_good = rx_aligned_i && !rx_enc_err_i;
    w_win_start  = (r_timer == 24'd0);
    w_win_last   = (r_timer == c_win_last);
    w_err_sum    = w_win_start ? 9'(rx_enc_err_i) : ({1'b0, r_err_cnt} + 9'(rx_enc_err_i));
    w_state_next = r_state;
    if (r_state != S_IDLE && (!enable_i || los_i)) begin
      w_state_next = S_IDLE;
    end else if ((r_state inside {S_RESET_PHY, S_WAIT_RST_DONE, S_WAIT_ALIGN, S_LINK_UP})
                 && !pll_locked_i) begin
      w_state_next = S_BACKOFF;
    end else begin
      case (r_state)
        S_IDLE:
          if (enable_i && !los_i) w_state_next = S_WAIT_PLL;
        S_WAIT_PLL:
          if (pll_locked_i && r_run_cnt == 4'd7) w_state_next = S_RESET_PHY;
        S_RESET_PHY:
          if (r_timer == c_rst_last) w_state_next = S_WAIT_RST_DONE;
        S_WAIT_RST_DONE:
          if (gtp_reset_done_i) w_state_next = S_WAIT_ALIGN;
          else if (r_timer == c_align_last) w_state_next = S_BACKOFF;
        S_WAIT_ALIGN:
          if (w_align_good && r_run_cnt == 4'd15) w_state_next = S_LINK_UP;
          else if (r_timer == c_align_last) w_state_next = S_BACKOFF;
        S_LINK_UP:
          if (!rx_aligned_i || w_err_sum >= c_err_thresh) w_state_next = S_BACKOFF;
        S_BACKOFF:
          if (r_timer == c_backoff_last) w_state_next = S_WAIT_PLL;
        default:
          w_state_next = S_IDLE;
      endcase
    end
    w_state_change = (w_state_next != r_state);
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_run_cnt   <= '0;
      r_err_cnt   <= '0;
      r_gtp_rst   <= 1'b1;
      r_tx_en     <= 1'b0;
      r_link_up   <= 1'b0;
      r_retry_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_state_change) begin
        r_timer   <= '0;
        r_run_cnt <= '0;
        r_err_cnt <= '0;
      end else begin
        if (r_state == S_LINK_UP) r_timer <= w_win_last ? '0 : r_timer + 24'd1;
        else if (r_timer != '1)   r_timer <= r_timer + 24'd1;
        case (r_state)
          S_WAIT_PLL:   r_run_cnt <= pll_locked_i ? r_run_cnt + 4'd1 : '0;
          S_WAIT_ALIGN: r_run_cnt <= w_align_good ? r_run_cnt + 4'd1 : '0;
          default:      r_run_cnt <= '0;
        endcase
        r_err_cnt <= (r_state == S_LINK_UP) ? w_err_sum[7:0] : '0;
      end
      // Outputs decode the next state so they move together with state_o.
      r_gtp_rst <= (w_state_next inside {S_IDLE, S_WAIT_PLL, S_RESET_PHY, S_BACKOFF});
      r_tx_en   <= (w_state_next inside {S_WAIT_ALIGN, S_LINK_UP});
      r_link_up <= (w_state_next == S_LINK_UP);
      if (w_state_next == S_BACKOFF && r_state != S_BACKOFF && r_retry_cnt != 8'hFF)
        r_retry_cnt <= r_retry_cnt + 8'd1;
    end
  end

  assign state_o     = r_state;
  assign gtp_rst_o   = r_gtp_rst;
  assign tx_enable_o = r_tx_en;
  assign link_up_o   = r_link_up;
  assign retry_cnt_o = r_retry_cnt;

`ifdef WR_LINK_SEQ_STATS_EN
  logic [15:0] r_link_up_cnt;
  logic [31:0] r_err_total;

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_link_up_cnt <= '0;
      r_err_total   <= '0;
    end else begin
      if (w_state_next == S_LINK_UP && r_state != S_LINK_UP && r_link_up_cnt != 16'hFFFF)
        r_link_up_cnt <= r_link_up_cnt + 16'd1;
      if (rx_enc_err_i)
        r_err_total <= r_err_total + 32'd1;
    end
  end

  assign link_up_cnt_o = r_link_up_cnt;
  assign err_total_o   = r_err_total;
`else
  assign link_up_cnt_o = '0;
  assign err_total_o   = '0;
`endif

endmodule

// File: tb/tb_wr_phy_link_sequencer.sv
// Randomized self-checking bench for wr_phy_link_sequencer (g_simulation=1 timers).
// Expected timings come from the sequence rules: 8 lock cycles, 16 reset, 256 timeout, 64 backoff, 128-cycle windows.
module tb_wr_phy_link_sequencer;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_WPLL = 3'd1, ST_RST = 3'd2, ST_WDONE = 3'd3,
                         ST_WALIGN = 3'd4, ST_UP = 3'd5, ST_BACKOFF = 3'd6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, los, pll, done, aligned, enc_err;
  logic        gtp_rst, tx_en, link_up;
  logic [2:0]  state;
  logic [7:0]  retry_cnt;
  logic [15:0] link_up_cnt;
  logic [31:0] err_total;

  int n_checks = 0;
  int n_errors = 0;
  int exp_retry = 0;
  int exp_luc = 0;
  int exp_errt = 0;
  bit err_pat [640];

  wr_phy_link_sequencer #(.g_simulation(1)) dut (
    .clk_sys_i(clk), .rst_n_i(rst_n), .enable_i(enable), .los_i(los),
    .pll_locked_i(pll), .gtp_rst_o(gtp_rst), .gtp_reset_done_i(done),
    .rx_aligned_i(aligned), .rx_enc_err_i(enc_err), .tx_enable_o(tx_en),
    .link_up_o(link_up), .state_o(state), .retry_cnt_o(retry_cnt),
    .link_up_cnt_o(link_up_cnt), .err_total_o(err_total)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_err(input bit e);
    enc_err = e;
    if (e) exp_errt++;
    step();
    enc_err = 1'b0;
  endtask

  task automatic bump_retry();
    if (exp_retry < 255) exp_retry++;
  endtask

  task automatic measure(input logic [2:0] s, input int budget, output int n);
    n = 0;
    while (state == s && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state != s && n < budget) begin
      step();
      n++;
    end
    check_val(tag, state, s);
  endtask

  task automatic go_idle();
    enable = 1'b0;
    step();
    check_val("idle_state", state, ST_IDLE);
    check_val("idle_gtp_rst", gtp_rst, 1);
    check_val("idle_tx_en", tx_en, 0);
    check_val("idle_link_up", link_up, 0);
  endtask

  // From IDLE: full bring-up; reset-done arrives d cycles after reset release,
  // optional single error at WAIT_ALIGN offset err_at restarts the 16-cycle qualification.
  task automatic bring_up(input int d, input int err_at);
    int n;
    enable = 1'b1; los = 1'b0; pll = 1'b1; done = 1'b0; aligned = 1'b1;
    step();
    check_val("bu_wait_pll", state, ST_WPLL);
    measure(ST_WPLL, 20, n);
    check_val("bu_pll_len", n, 8);
    check_val("bu_rst_gtp", gtp_rst, 1);
    measure(ST_RST, 40, n);
    check_val("bu_rst_len", n, 16);
    check_val("bu_wdone_gtp", gtp_rst, 0);
    repeat (d) step();
    check_val("bu_wdone_state", state, ST_WDONE);
    done = 1'b1;
    step();
    check_val("bu_align_state", state, ST_WALIGN);
    check_val("bu_align_tx", tx_en, 1);
    n = 0;
    while (state == ST_WALIGN && n < 60) begin
      step_err(n == err_at);
      n++;
    end
    check_val("bu_align_len", n, (err_at >= 0) ? err_at + 17 : 16);
    check_val("bu_up_state", state, ST_UP);
    check_val("bu_up_link", link_up, 1);
    check_val("bu_up_retry", retry_cnt, exp_retry);
    exp_luc++;
    $display("bring_up d=%0d err_at=%0d align_cycles=%0d", d, err_at, n);
  endtask

  task automatic fill_window(input int w, input int cnt);
    int c = 0;
    int o;
    while (c < cnt) begin
      o = $urandom_range(0, 127);
      if (!err_pat[w*128 + o]) begin
        err_pat[w*128 + o] = 1'b1;
        c++;
      end
    end
  endtask

  // Starts on the LINK_UP entry cycle; windows are consecutive 128-cycle blocks from entry.
  task automatic window_test();
    int wcnt [5];
    int w;
    bit dropped = 1'b0;
    for (int i = 0; i < 640; i++) err_pat[i] = 1'b0;
    for (int i = 113; i < 128; i++) err_pat[i] = 1'b1;
    for (int i = 128; i < 143; i++) err_pat[i] = 1'b1;
    fill_window(2, 15);
    fill_window(3, 15);
    fill_window(4, 16);
    for (int i = 0; i < 5; i++) wcnt[i] = 0;
    for (int t = 0; t < 640; t++) begin
      w = t / 128;
      if (err_pat[t]) wcnt[w]++;
      step_err(err_pat[t]);
      if (wcnt[w] >= 16) begin
        check_val("win_drop_state", state, ST_BACKOFF);
        check_val("win_drop_link", link_up, 0);
        dropped = 1'b1;
        $display("window test: drop after cycle %0d in window %0d", t, w);
        break;
      end else begin
        check_val("win_hold_state", state, ST_UP);
      end
    end
    check_val("win_dropped", dropped, 1);
    bump_retry();
    check_val("win_retry", retry_cnt, exp_retry);
  endtask

  initial begin
    int n, k;
    rst_n = 1'b0; enable = 1'b0; los = 1'b0; pll = 1'b0;
    done = 1'b0; aligned = 1'b0; enc_err = 1'b0;
    repeat (3) step();
    check_val("rst_state", state, ST_IDLE);
    check_val("rst_gtp_rst", gtp_rst, 1);
    check_val("rst_tx_en", tx_en, 0);
    check_val("rst_link_up", link_up, 0);
    check_val("rst_retry", retry_cnt, 0);
    check_val("rst_luc", link_up_cnt, 0);
    check_val("rst_errt", err_total, 0);
    rst_n = 1'b1;
    step();

    // IDLE holds while LOS is present even with enable set.
    enable = 1'b1; los = 1'b1;
    repeat (3) step();
    check_val("idle_los_hold", state, ST_IDLE);
    enable = 1'b0; los = 1'b0;
    step();
    $display("idle hold under los done");

    bring_up(20, -1);
    window_test();
    go_idle();

    // LOS together with a threshold-reaching error: IDLE wins over BACKOFF.
    bring_up($urandom_range(1, 60), $urandom_range(0, 14));
    repeat (15) step_err(1'b1);
    check_val("los_pre_state", state, ST_UP);
    los = 1'b1;
    step_err(1'b1);
    check_val("los_state", state, ST_IDLE);
    check_val("los_gtp_rst", gtp_rst, 1);
    check_val("los_tx_en", tx_en, 0);
    check_val("los_link", link_up, 0);
    check_val("los_retry", retry_cnt, exp_retry);
    los = 1'b0;
    $display("los vs threshold done");

    // Reset-done never arrives: timeout, backoff, back to WAIT_PLL.
    pll = 1'b1; done = 1'b0;
    wait_state(ST_WDONE, 40, "to_reach_wdone");
    measure(ST_WDONE, 300, n);
    check_val("to_wdone_len", n, 256);
    check_val("to_backoff", state, ST_BACKOFF);
    bump_retry();
    check_val("to_retry", retry_cnt, exp_retry);
    measure(ST_BACKOFF, 100, n);
    check_val("to_backoff_len", n, 64);
    check_val("to_wpll", state, ST_WPLL);
    $display("reset-done timeout done, retry=%0d", exp_retry);

    // One-cycle PLL drop in WAIT_ALIGN.
    done = 1'b1; aligned = 1'b0;
    wait_state(ST_WALIGN, 60, "pd_reach_align");
    k = $urandom_range(0, 50);
    repeat (k) step();
    check_val("pd_still_align", state, ST_WALIGN);
    pll = 1'b0;
    step();
    check_val("pd_backoff", state, ST_BACKOFF);
    bump_retry();
    check_val("pd_retry", retry_cnt, exp_retry);
    pll = 1'b1;
    measure(ST_BACKOFF, 100, n);
    check_val("pd_backoff_len", n, 64);
    check_val("pd_wpll", state, ST_WPLL);
    $display("pll drop in align after %0d cycles done", k);

    // PLL pulsing low every 5 cycles never qualifies; 7 highs do not, 8 do.
    n = 0;
    for (int i = 0; i < 100; i++) begin
      pll = (i % 5) != 4;
      step();
      if (state != ST_WPLL) n++;
    end
    check_val("pulse_left_wpll", n, 0);
    pll = 1'b1;
    repeat (7) step();
    check_val("pll7_hold", state, ST_WPLL);
    pll = 1'b0;
    step();
    check_val("pll_low_hold", state, ST_WPLL);
    pll = 1'b1;
    repeat (7) step();
    check_val("pll8_pre", state, ST_WPLL);
    step();
    check_val("pll8_exit", state, ST_RST);
    $display("pll qualification done");
    go_idle();

    bring_up($urandom_range(1, 100), ($urandom_range(0, 1) == 1) ? $urandom_range(0, 14) : -1);
    go_idle();

    // Retry counter saturation via PLL drops in RESET_PHY.
    enable = 1'b1; pll = 1'b1; done = 1'b0; aligned = 1'b0;
    step();
    check_val("rt_start", state, ST_WPLL);
    for (int it = 0; it < 300; it++) begin
      wait_state(ST_RST, 20, "rt_reach_rst");
      k = $urandom_range(0, 10);
      repeat (k) step();
      pll = 1'b0;
      step();
      check_val("rt_backoff", state, ST_BACKOFF);
      bump_retry();
      check_val("rt_cnt", retry_cnt, exp_retry);
      pll = 1'b1;
      wait_state(ST_WPLL, 80, "rt_back_wpll");
    end
    check_val("rt_saturated", retry_cnt, 255);
    $display("retry saturation done, retry=%0d", retry_cnt);

`ifdef WR_LINK_SEQ_STATS_EN
    check_val("stat_luc", link_up_cnt, exp_luc);
    check_val("stat_errt", err_total, exp_errt);
`else
    check_val("stat_luc_off", link_up_cnt, 0);
    check_val("stat_errt_off", err_total, 0);
`endif
    $display("stats: link_ups=%0d errors=%0d", exp_luc, exp_errt);

    // Asynchronous reset mid-sequence clears everything without a clock edge.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_val("arst_state", state, ST_IDLE);
    check_val("arst_gtp_rst", gtp_rst, 1);
    check_val("arst_tx_en", tx_en, 0);
    check_val("arst_retry", retry_cnt, 0);
    check_val("arst_luc", link_up_cnt, 0);
    check_val("arst_errt", err_total, 0);
    step();
    rst_n = 1'b1;
    $display("async reset done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
